// File: rtl/ctr_record_buffer_pkg.sv
// ============================================================================
// Package : riscv / ctr_record_buffer_pkg
// Brief   : Shared RISC-V CTR record types plus buffer-local helpers.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned CTR_DEPTH_MAX = 256;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [3:0] {
    CTR_TYPE_NONE    = 4'd0,
    CTR_TYPE_EXC     = 4'd1,
    CTR_TYPE_INTR    = 4'd2,
    CTR_TYPE_TRET    = 4'd3,
    CTR_TYPE_NTBR    = 4'd4,
    CTR_TYPE_TKBR    = 4'd5,
    CTR_TYPE_INDCALL = 4'd8,
    CTR_TYPE_DIRCALL = 4'd9,
    CTR_TYPE_INDJMP  = 4'd10,
    CTR_TYPE_DIRJMP  = 4'd11,
    CTR_TYPE_CORSWAP = 4'd12,
    CTR_TYPE_RET     = 4'd13,
    CTR_TYPE_INDLJMP = 4'd14,
    CTR_TYPE_DIRLJMP = 4'd15
  } ctr_type_t;

  // PC bit 0 is always zero, so only PC[XLEN-1:1] is kept.
  typedef struct packed {
    logic [XLEN-2:0] pc;
    logic            v;
  } ctrsource_rv_t;

  typedef struct packed {
    logic [XLEN-2:0] pc;
    logic            misp;
  } ctrtarget_rv_t;

  typedef struct packed {
    ctrsource_rv_t source;
    ctrtarget_rv_t target;
    ctr_type_t     ctype;
  } ctr_entry_t;

endpackage

package ctr_record_buffer_pkg;

  import riscv::*;

  localparam int unsigned CTR_DEPTH_DEFAULT = 16;

  // Recording enable selected by the privilege of the source instruction;
  // the reserved encoding never records.
  function automatic logic ctr_priv_enabled(input priv_lvl_t priv,
                                            input logic en_m,
                                            input logic en_s,
                                            input logic en_u);
    logic en;
    en = 1'b0;
    case (priv)
      PRIV_LVL_M: en = en_m;
      PRIV_LVL_S: en = en_s;
      PRIV_LVL_U: en = en_u;
      default:    en = 1'b0;
    endcase
    return en;
  endfunction

  // Value presented on the read port for an empty or out-of-range slot.
  function automatic ctr_entry_t ctr_entry_blank();
    ctr_entry_t e;
    e       = '0;
    e.ctype = CTR_TYPE_NONE;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctr_record_buffer_if.sv
// ============================================================================
// Interface : ctr_record_buffer_if
// Brief     : Record capture bus from the serializer and CSR read port.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctr_record_buffer_if;

  import riscv::*;

  ctrsource_rv_t rec_source_i;
  ctrtarget_rv_t rec_target_i;
  ctr_type_t     rec_type_i;
  priv_lvl_t     rec_priv_i;

  logic [7:0]    rd_idx_i;
  ctrsource_rv_t rd_source_o;
  ctrtarget_rv_t rd_target_o;
  ctr_type_t     rd_data_o;

  modport master (
    output rec_source_i, rec_target_i, rec_type_i, rec_priv_i, rd_idx_i,
    input  rd_source_o, rd_target_o, rd_data_o
  );

  modport slave (
    input  rec_source_i, rec_target_i, rec_type_i, rec_priv_i, rd_idx_i,
    output rd_source_o, rd_target_o, rd_data_o
  );

endinterface

`default_nettype wire

// File: rtl/ctr_record_buffer_priv_filter.sv
// ============================================================================
// Module : ctr_priv_filter
// Brief  : Combinational record qualification by privilege and type inhibit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctr_priv_filter
  import riscv::*;
  import ctr_record_buffer_pkg::*;
(
  input  logic        valid_i,
  input  priv_lvl_t   priv_i,
  input  ctr_type_t   type_i,
  input  logic        en_m_i,
  input  logic        en_s_i,
  input  logic        en_u_i,
  input  logic [15:0] type_inhibit_i,
  output logic        pass_o
);

  // A record passes when offered, its privilege is enabled, its type is not
  // inhibited, and it carries a real type (NONE is never recorded).
  always_comb begin
    pass_o = valid_i
           & ctr_priv_enabled(priv_i, en_m_i, en_s_i, en_u_i)
           & ~type_inhibit_i[type_i]
           & (type_i != CTR_TYPE_NONE);
  end

endmodule

`default_nettype wire

// File: rtl/ctr_record_buffer.sv
// ============================================================================
// Module : ctr_record_buffer
// Brief  : Circular Control Transfer Record store with filtering, freeze,
//          write-pointer control and a logically indexed read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctr_record_buffer
  import riscv::*;
  import ctr_record_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = CTR_DEPTH_DEFAULT,
  localparam int unsigned PtrW  = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ctr_record_buffer_if.slave  rec_if,
  input  logic                en_m_i,
  input  logic                en_s_i,
  input  logic                en_u_i,
  input  logic [15:0]         type_inhibit_i,
  input  logic                freeze_set_i,
  input  logic                freeze_clr_i,
  input  logic                clear_i,
  input  logic                wrptr_we_i,
  input  logic [PtrW-1:0]     wrptr_wdata_i,
  output logic [PtrW-1:0]     wrptr_o,
  output logic                frozen_o
);

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  logic [PtrW-1:0]  wrptr_q, wrptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             frozen_q, frozen_d;
  ctr_entry_t       entry_q [DEPTH];

  logic             filt_pass;
  logic             qual;
  logic             capture;
  ctr_entry_t       wr_entry;
  logic [PtrW-1:0]  rd_phys;
  logic             rd_hit;
  ctr_entry_t       rd_entry;

  ctr_priv_filter u_filter (
    .valid_i        (rec_if.rec_source_i.v),
    .priv_i         (rec_if.rec_priv_i),
    .type_i         (rec_if.rec_type_i),
    .en_m_i         (en_m_i),
    .en_s_i         (en_s_i),
    .en_u_i         (en_u_i),
    .type_inhibit_i (type_inhibit_i),
    .pass_o         (filt_pass)
  );

  // Qualify the offered record; a pointer write steals the slot from it.
  always_comb begin
    qual            = filt_pass & ~frozen_q & ~clear_i;
    capture         = qual & ~wrptr_we_i;
    wr_entry.source = rec_if.rec_source_i;
    wr_entry.target = rec_if.rec_target_i;
    wr_entry.ctype  = rec_if.rec_type_i;
  end

  // Next pointer/valid/freeze state: clear beats pointer write beats capture.
  always_comb begin
    wrptr_d  = wrptr_q;
    valid_d  = valid_q;
    frozen_d = freeze_set_i | (frozen_q & ~freeze_clr_i);
    if (clear_i) begin
      wrptr_d = '0;
      valid_d = '0;
    end else if (wrptr_we_i) begin
      wrptr_d = wrptr_wdata_i;
    end else if (capture) begin
      valid_d[wrptr_q] = 1'b1;
      wrptr_d          = wrptr_q + PtrW'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrptr_q  <= '0;
      valid_q  <= '0;
      frozen_q <= 1'b0;
    end else begin
      wrptr_q  <= wrptr_d;
      valid_q  <= valid_d;
      frozen_q <= frozen_d;
    end
  end

  // Record payload storage; contents are only visible through valid bits.
  always_ff @(posedge clk_i) begin
    if (capture && !rst_i) begin
      entry_q[wrptr_q] <= wr_entry;
    end
  end

  // Logical read: index 0 is the slot just behind the write pointer.
  always_comb begin
    rd_phys  = wrptr_q - PtrW'(1) - rec_if.rd_idx_i[PtrW-1:0];
    rd_hit   = ({1'b0, rec_if.rd_idx_i} < DEPTH_W) && valid_q[rd_phys];
    rd_entry = rd_hit ? entry_q[rd_phys] : ctr_entry_blank();
    rec_if.rd_source_o = rd_entry.source;
    rec_if.rd_target_o = rd_entry.target;
    rec_if.rd_data_o   = rd_entry.ctype;
    wrptr_o            = wrptr_q;
    frozen_o           = frozen_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ctr_record_buffer.sv
// ============================================================================
// Module : tb_ctr_record_buffer
// Brief  : Self-checking bench for ctr_record_buffer against a record model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctr_record_buffer;

  import riscv::*;

  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_m = 1'b0, en_s = 1'b0, en_u = 1'b0;
  logic [15:0]   inhibit = '0;
  logic          fset = 1'b0, fclr = 1'b0, clr = 1'b0, we = 1'b0;
  logic [PW-1:0] wdata = '0;
  logic [PW-1:0] wrptr;
  logic          frozen;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a ring of records addressed by a pointer with modulo arithmetic.
  logic [30:0] m_src  [DEPTH];
  logic [30:0] m_tgt  [DEPTH];
  logic        m_misp [DEPTH];
  logic [3:0]  m_type [DEPTH];
  bit          m_val  [DEPTH];
  int          m_wp;
  bit          m_frz;

  ctr_record_buffer_if bus_if ();

  ctr_record_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rec_if         (bus_if),
    .en_m_i         (en_m),
    .en_s_i         (en_s),
    .en_u_i         (en_u),
    .type_inhibit_i (inhibit),
    .freeze_set_i   (fset),
    .freeze_clr_i   (fclr),
    .clear_i        (clr),
    .wrptr_we_i     (we),
    .wrptr_wdata_i  (wdata),
    .wrptr_o        (wrptr),
    .frozen_o       (frozen)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    m_wp  = 0;
    m_frz = 1'b0;
  endtask

  task automatic set_rec(input logic v, input int unsigned src, input int unsigned tgt,
                         input logic misp, input int ty, input int pv);
    bus_if.rec_source_i.v    = v;
    bus_if.rec_source_i.pc   = 31'(src >> 1);
    bus_if.rec_target_i.pc   = 31'(tgt >> 1);
    bus_if.rec_target_i.misp = misp;
    bus_if.rec_type_i        = ctr_type_t'(4'(ty));
    bus_if.rec_priv_i        = priv_lvl_t'(2'(pv));
  endtask

  // Return every control input to a state that leaves the DUT untouched.
  task automatic idle();
    bus_if.rec_source_i = '0;
    fset = 1'b0; fclr = 1'b0; clr = 1'b0; we = 1'b0;
  endtask

  // One clock edge; the model applies the same rules to the same inputs.
  task automatic tick();
    bit pok, q;
    int pv, ty;
    pv = int'(bus_if.rec_priv_i);
    ty = int'(bus_if.rec_type_i);
    pok = (pv == 3) ? en_m : (pv == 1) ? en_s : (pv == 0) ? en_u : 1'b0;
    q = bus_if.rec_source_i.v && pok && !inhibit[ty] && (ty != 0) && !m_frz && !clr;
    @(posedge clk);
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
      m_wp = 0;
    end else if (we) begin
      m_wp = int'(wdata);
    end else if (q) begin
      m_src[m_wp]  = bus_if.rec_source_i.pc;
      m_tgt[m_wp]  = bus_if.rec_target_i.pc;
      m_misp[m_wp] = bus_if.rec_target_i.misp;
      m_type[m_wp] = 4'(ty);
      m_val[m_wp]  = 1'b1;
      m_wp = (m_wp + 1) % DEPTH;
    end
    if (fset) m_frz = 1'b1;
    else if (fclr) m_frz = 1'b0;
    #1;
  endtask

  task automatic check_idx(input int idx);
    int phys;
    logic [31:0] es, et;
    logic [3:0]  ety;
    bus_if.rd_idx_i = 8'(idx);
    #1;
    phys = (m_wp - 1 - idx + 512) % DEPTH;
    es = '0; et = '0; ety = 4'd0;
    if (idx < DEPTH && m_val[phys]) begin
      es  = {m_src[phys], 1'b1};
      et  = {m_tgt[phys], m_misp[phys]};
      ety = m_type[phys];
    end
    check($sformatf("src[%0d]", idx), 64'(bus_if.rd_source_o), 64'(es));
    check($sformatf("tgt[%0d]", idx), 64'(bus_if.rd_target_o), 64'(et));
    check($sformatf("type[%0d]", idx), 64'(bus_if.rd_data_o), 64'(ety));
  endtask

  task automatic check_state();
    check("wrptr", 64'(wrptr), 64'(m_wp));
    check("frozen", 64'(frozen), 64'(m_frz));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int start_wp;
    idle();
    set_rec(1'b0, 0, 0, 1'b0, 0, 0);
    bus_if.rd_idx_i = '0;
    model_reset();
    #12;
    // Reset state.
    for (int i = 0; i < 4; i++) check_idx(i);
    check_state();
    @(negedge clk);
    rst = 1'b0;

    // Three back-to-back M-mode records.
    en_m = 1'b1;
    set_rec(1'b1, 32'h1000, 32'h1100, 1'b0, 1, 3); tick();
    set_rec(1'b1, 32'h2000, 32'h2100, 1'b1, 1, 3); tick();
    set_rec(1'b1, 32'h3000, 32'h3100, 1'b0, 1, 3); tick();
    idle();
    check_state();
    check("tp_wrptr3", 64'(wrptr), 64'd3);
    bus_if.rd_idx_i = 8'd0; #1;
    check("tp_idx0_pc", 64'(bus_if.rd_source_o.pc), 64'(32'h3000 >> 1));
    bus_if.rd_idx_i = 8'd2; #1;
    check("tp_idx2_pc", 64'(bus_if.rd_source_o.pc), 64'(32'h1000 >> 1));
    for (int i = 0; i < 4; i++) check_idx(i);

    // Wrap-around with 18 records.
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      set_rec(1'b1, 32'h100 * k, 32'h40 * k, k[0], 9, 3);
      tick();
    end
    idle();
    check_state();
    check("tp_wrptr_wrap", 64'(wrptr), 64'd2);
    bus_if.rd_idx_i = 8'd0; #1;
    check("tp_wrap_idx0", 64'(bus_if.rd_source_o.pc), 64'((32'h100 * 18) >> 1));
    bus_if.rd_idx_i = 8'd15; #1;
    check("tp_wrap_idx15", 64'(bus_if.rd_source_o.pc), 64'((32'h100 * 3) >> 1));
    bus_if.rd_idx_i = 8'd16; #1;
    check("tp_wrap_idx16", 64'(bus_if.rd_data_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) check_idx(i);
    check_idx(16);
    check_idx(255);

    // Privilege and type filtering.
    en_u = 1'b0;
    inhibit = 16'h0010;
    start_wp = m_wp;
    set_rec(1'b1, 32'h7000, 32'h7100, 1'b0, 1, 0); tick();
    set_rec(1'b1, 32'h7200, 32'h7300, 1'b0, 4, 3); tick();
    set_rec(1'b1, 32'h7400, 32'h7500, 1'b0, 0, 3); tick();
    idle();
    check_state();
    check("tp_filter_wp", 64'(wrptr), 64'(start_wp));
    check_idx(0);

    // Freeze coincident with a capture.
    set_rec(1'b1, 32'h8000, 32'h8100, 1'b1, 5, 3);
    fset = 1'b1;
    tick();
    idle();
    check_state();
    check("tp_frz_set", 64'(frozen), 64'd1);
    check_idx(0);
    set_rec(1'b1, 32'h8200, 32'h8300, 1'b0, 5, 3); tick();
    idle();
    check_state();
    check_idx(0);
    fclr = 1'b1; tick(); idle();
    set_rec(1'b1, 32'h8400, 32'h8500, 1'b0, 5, 3); tick();
    idle();
    check_state();
    check_idx(0);

    // Clear beats pointer write and capture.
    set_rec(1'b1, 32'h9000, 32'h9100, 1'b0, 1, 3);
    clr = 1'b1; we = 1'b1; wdata = 4'd5;
    tick();
    idle();
    check_state();
    check("tp_clr_wp", 64'(wrptr), 64'd0);
    for (int i = 0; i < 4; i++) check_idx(i);

    // Pointer write drops the simultaneous capture.
    set_rec(1'b1, 32'h9200, 32'h9300, 1'b0, 1, 3); tick();
    set_rec(1'b1, 32'h9400, 32'h9500, 1'b0, 1, 3);
    we = 1'b1; wdata = 4'd9;
    tick();
    idle();
    check_state();
    for (int i = 0; i < DEPTH; i++) check_idx(i);

    // Randomized traffic.
    inhibit = 16'h0;
    for (int n = 0; n < 400; n++) begin
      en_m = ($urandom_range(0, 9) != 0);
      en_s = ($urandom_range(0, 3) != 0);
      en_u = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 19) == 0) inhibit = 16'($urandom);
      set_rec($urandom_range(0, 4) != 0, $urandom, $urandom, 1'($urandom),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      fset  = ($urandom_range(0, 29) == 0);
      fclr  = ($urandom_range(0, 4) == 0);
      clr   = ($urandom_range(0, 59) == 0);
      we    = ($urandom_range(0, 29) == 0);
      wdata = PW'($urandom);
      tick();
      idle();
      check_state();
      check_idx(0);
      check_idx(int'($urandom_range(0, 20)));
      if (n % 100 == 99)
        for (int i = 0; i < DEPTH; i++) check_idx(i);
    end

    // Asynchronous reset with a record in flight.
    en_m = 1'b1; fclr = 1'b1; tick(); idle();
    set_rec(1'b1, 32'hA000, 32'hA100, 1'b0, 1, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_state();
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    check_state();
    for (int i = 0; i < 4; i++) check_idx(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
